// File: rtl/stack_unit.sv
// Multi-cycle PUSH/POP/CALL/RET sequencer between the register-bank SP port and data memory.
// Define STACK_BOUNDS_CHECK_EN to enable overflow/underflow detection and the FAULT state.
module stack_unit #(
    parameter logic [31:0] SP_STEP      = 32'd1,
    parameter logic [31:0] STACK_TOP    = 32'd16,
    parameter logic [31:0] STACK_BOTTOM = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] sp_in,
    input  logic [31:0] push_data,
    input  logic [31:0] pc_next,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    output logic [31:0] WriteDataSP,
    output logic        SPWrite,
    output logic [31:0] pop_data,
    output logic        pop_valid,
    output logic        ret_valid,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_CALL = 2'b10;
    localparam logic [1:0] OP_RET  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_READ   = 3'd2,
        S_WAIT   = 3'd3,
        S_FINISH = 3'd4
`ifdef STACK_BOUNDS_CHECK_EN
        , S_FAULT = 3'd5
`endif
    } state_t;

    if (STACK_TOP <= STACK_BOTTOM) begin : g_bad_range
        $error("stack_unit: STACK_TOP must be above STACK_BOTTOM");
    end

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] sp_q, sp_d;
    logic [31:0] data_q, data_d;
    logic [31:0] new_sp_q, new_sp_d;
    logic [31:0] pop_data_q, pop_data_d;

`ifdef STACK_BOUNDS_CHECK_EN
    logic bounds_viol;
    // op[0]==0 selects the writing ops (PUSH, CALL); unsigned compares throughout
    assign bounds_viol = op[0] ? (sp_in >= STACK_TOP)
                               : (sp_in < (STACK_BOTTOM + SP_STEP));
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pop_data_q <= '0;
        end else begin
            state_q    <= state_d;
            pop_data_q <= pop_data_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q     <= op_d;
        sp_q     <= sp_d;
        data_q   <= data_d;
        new_sp_q <= new_sp_d;
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sp_d       = sp_q;
        data_d     = data_q;
        new_sp_d   = new_sp_q;
        pop_data_d = pop_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = op;
                    sp_d   = sp_in;
                    data_d = (op == OP_CALL) ? pc_next : push_data;
                    state_d = op[0] ? S_READ : S_WRITE;
`ifdef STACK_BOUNDS_CHECK_EN
                    if (bounds_viol) state_d = S_FAULT;
`endif
                end
            end
            S_WRITE: begin
                new_sp_d = sp_q - SP_STEP;
                state_d  = S_FINISH;
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT: begin
                pop_data_d = mem_rdata;
                new_sp_d   = sp_q + SP_STEP;
                state_d    = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
`ifdef STACK_BOUNDS_CHECK_EN
            S_FAULT:  state_d = S_IDLE;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        WriteDataSP = '0;
        SPWrite     = 1'b0;
        pop_valid   = 1'b0;
        ret_valid   = 1'b0;
        done        = 1'b0;
        fault       = 1'b0;
        case (state_q)
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = sp_q - SP_STEP;
                mem_wdata = data_q;
            end
            S_READ: begin
                mem_re   = 1'b1;
                mem_addr = sp_q;
            end
            S_FINISH: begin
                SPWrite     = 1'b1;
                WriteDataSP = new_sp_q;
                done        = 1'b1;
                pop_valid   = (op_q == OP_POP);
                ret_valid   = (op_q == OP_RET);
            end
`ifdef STACK_BOUNDS_CHECK_EN
            S_FAULT: begin
                done  = 1'b1;
                fault = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign pop_data = pop_data_q;
    assign busy     = (state_q != S_IDLE);

    // OP_PUSH is kept for readability of the encoding table
    logic unused_op_push;
    assign unused_op_push = (OP_PUSH == 2'b00);

endmodule
